// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM: shared period counter, debounced inc/dec buttons plus cfg writes, double-buffered duties.
// Latency: pwm_out/duty_mon are registered one cycle after cnt/active duty; duty changes commit at the period wrap.
// No backpressure: buttons and cfg writes are accepted every cycle. Optional macro PWM_PHASE_STAGGER_EN staggers channel phases.
module pwm_multi_ctrl #(
    parameter  int NUM_CH       = 4,
    parameter  int PERIOD       = 10,
    parameter  int STEP         = 1,
    parameter  int INIT_DUTY    = 5,
    parameter  int DEBOUNCE_DIV = 4,
    localparam int DW           = $clog2(PERIOD + 1),
    localparam int SW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic [SW-1:0]     ch_sel,
    input  logic              cfg_we,
    input  logic [SW-1:0]     cfg_ch,
    input  logic [DW-1:0]     cfg_duty,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [DW-1:0]     duty_mon,
    output logic              frame_start
);

    localparam int TW = $clog2(DEBOUNCE_DIV);

    // Button vectors: bit 0 = inc, bit 1 = dec
    logic [1:0]        r_meta;
    logic [1:0]        r_sync;
    logic [1:0]        r_s1;
    logic [1:0]        r_s2;
    logic [TW-1:0]     r_div;
    logic              w_tick;
    logic [1:0]        w_ev;

    logic [DW-1:0]     r_cnt;
    logic              w_wrap;
    logic              r_fs;

    logic [DW-1:0]     r_shadow     [NUM_CH];
    logic [DW-1:0]     w_shadow_nxt [NUM_CH];
    logic [DW-1:0]     r_active     [NUM_CH];
    logic [DW:0]       w_phase      [NUM_CH];
    logic [NUM_CH-1:0] w_pwm_nxt;
    logic [NUM_CH-1:0] r_pwm;
    logic [DW-1:0]     w_mon_nxt;
    logic [DW-1:0]     r_mon;

    // Requested duties above the period behave like a full-on duty, so clamp them.
    function automatic logic [DW-1:0] f_clamp(input logic [DW-1:0] v);
        return (v > DW'(PERIOD)) ? DW'(PERIOD) : v;
    endfunction

    // Saturating increment computed one bit wider so it can never wrap.
    function automatic logic [DW-1:0] f_inc(input logic [DW-1:0] v);
        logic [DW:0] s;
        s = {1'b0, v} + (DW+1)'(STEP);
        return (s > (DW+1)'(PERIOD)) ? DW'(PERIOD) : s[DW-1:0];
    endfunction

    // Decrement that floors at zero.
    function automatic logic [DW-1:0] f_dec(input logic [DW-1:0] v);
        return (v >= DW'(STEP)) ? (v - DW'(STEP)) : '0;
    endfunction

    assign w_tick = (r_div == TW'(DEBOUNCE_DIV - 1));
    assign w_ev   = r_s1 & ~r_s2 & {2{w_tick}};
    assign w_wrap = ena && (r_cnt == DW'(PERIOD - 1));

    // Two-flop synchroniser for the raw async buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {dec_btn, inc_btn};
            r_sync <= r_meta;
        end
    end

    // Debounce tick divider, free-running independent of ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + TW'(1);
    end

    // Slow sampling on each tick; a rising edge between samples becomes one press event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (w_tick) begin
            r_s1 <= r_sync;
            r_s2 <= r_s1;
        end
    end

    // Period counter and frame_start pulse; frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_fs  <= 1'b0;
        end else begin
            r_fs <= w_wrap;
            if (w_wrap)   r_cnt <= '0;
            else if (ena) r_cnt <= r_cnt + DW'(1);
        end
    end

    // Next shadow duty: cfg write wins, otherwise a lone inc or dec event on ch_sel
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
            if (cfg_we) begin
                if (cfg_ch == SW'(i)) w_shadow_nxt[i] = f_clamp(cfg_duty);
            end else if (ch_sel == SW'(i)) begin
                if (w_ev[0] && !w_ev[1])      w_shadow_nxt[i] = f_inc(r_shadow[i]);
                else if (w_ev[1] && !w_ev[0]) w_shadow_nxt[i] = f_dec(r_shadow[i]);
            end
        end
    end

    // Shadow duties take updates at any time; active duties copy them only at the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= DW'(INIT_DUTY);
                r_active[i] <= DW'(INIT_DUTY);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= w_shadow_nxt[i];
                if (w_wrap) r_active[i] <= r_shadow[i];
            end
        end
    end

    // Per-channel phase count and compare against the active duty
    always_comb begin
        w_pwm_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
            w_phase[i] = {1'b0, r_cnt} + (DW+1)'(i * (PERIOD / NUM_CH));
            if (w_phase[i] >= (DW+1)'(PERIOD)) w_phase[i] = w_phase[i] - (DW+1)'(PERIOD);
`else
            w_phase[i] = {1'b0, r_cnt};
`endif
            w_pwm_nxt[i] = ena && (w_phase[i] < {1'b0, r_active[i]});
        end
    end

    // Monitor mux; channel numbers beyond NUM_CH read as zero
    always_comb begin
        w_mon_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == SW'(i)) w_mon_nxt = r_active[i];
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
            r_mon <= DW'(INIT_DUTY);
        end else begin
            r_pwm <= w_pwm_nxt;
            r_mon <= w_mon_nxt;
        end
    end

    assign pwm_out     = r_pwm;
    assign duty_mon    = r_mon;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl with default parameters (4 channels, period 10).
// Expected per-frame high counts and duty_mon are queued when stimulus is applied, then popped after a frame is observed.
module tb_pwm_multi_ctrl;
    localparam int NCH = 4;
    localparam int PER = 10;
    localparam int DW  = 4;
    localparam int SW  = 2;

    logic           clk = 1'b0;
    logic           rst_n, ena, inc_btn, dec_btn, cfg_we;
    logic [SW-1:0]  ch_sel, cfg_ch;
    logic [DW-1:0]  cfg_duty;
    logic [NCH-1:0] pwm_out;
    logic [DW-1:0]  duty_mon;
    logic           frame_start;

    int n_checks = 0;
    int n_pass   = 0;
    int sb_q[$];
    int exp_duty[NCH];
    int obs_hi[NCH];
    int obs_fs;
    bit obs_to;

    always #5 clk = ~clk;

    pwm_multi_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .ch_sel(ch_sel), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_duty(cfg_duty),
        .pwm_out(pwm_out), .duty_mon(duty_mon), .frame_start(frame_start)
    );

    task automatic wait_frame();
        obs_to = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                obs_to = 1'b0;
                break;
            end
        end
    endtask

    // Observe one full period after a frame_start: high cycles per channel and frame_start count.
    task automatic measure_frame();
        wait_frame();
        obs_fs = 0;
        for (int i = 0; i < NCH; i++) obs_hi[i] = 0;
        for (int k = 0; k < PER; k++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) obs_hi[i] += int'(pwm_out[i]);
            obs_fs += int'(frame_start);
        end
    endtask

    task automatic push_expect();
        for (int i = 0; i < NCH; i++) sb_q.push_back(exp_duty[i]);
        sb_q.push_back(exp_duty[ch_sel]);
    endtask

    task automatic press(input logic i_inc, input logic i_dec);
        @(negedge clk);
        inc_btn = i_inc;
        dec_btn = i_dec;
        repeat (16) @(negedge clk);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [SW-1:0] ch, input logic [DW-1:0] duty);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_duty = duty;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pwm_out !== 4'h0) $display("FAIL reset_pwm got=%h exp=0", pwm_out); else n_pass++;
        n_checks++;
        if (frame_start !== 1'b0) $display("FAIL reset_fs got=%b exp=0", frame_start); else n_pass++;
        n_checks++;
        if (duty_mon !== 4'd5) $display("FAIL reset_mon got=%0d exp=5", duty_mon); else n_pass++;
        rst_n = 1'b1;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) break;
        end
        n_checks++;
        if (k != PER) $display("FAIL first_frame_start got_cycle=%0d exp_cycle=%0d", k, PER); else n_pass++;
    endtask

    task automatic test_defaults();
        ch_sel = 2'd0;
        for (int i = 0; i < NCH; i++) exp_duty[i] = 5;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL defaults idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
        n_checks++;
        if (obs_to || obs_fs !== 1) $display("FAIL defaults_fs got=%0d timeout=%0d exp=1", obs_fs, obs_to); else n_pass++;
    endtask

    task automatic test_inc_press();
        ch_sel = 2'd2;
        press(1'b1, 1'b0);
        exp_duty[2] = 6;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL inc_press idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
        n_checks++;
        if (obs_to || obs_fs !== 1) $display("FAIL inc_press_fs got=%0d timeout=%0d exp=1", obs_fs, obs_to); else n_pass++;
    endtask

    task automatic test_bouncy();
        ch_sel = 2'd0;
        @(negedge clk); inc_btn = 1'b1;
        @(negedge clk); inc_btn = 1'b0;
        @(negedge clk); inc_btn = 1'b1;
        repeat (40) @(negedge clk);
        inc_btn = 1'b0;
        repeat (16) @(negedge clk);
        exp_duty[0] = 6;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL bouncy idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_sat_high();
        ch_sel = 2'd1;
        cfg_write(2'd1, 4'd9);
        repeat (3) press(1'b1, 1'b0);
        exp_duty[1] = 10;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL sat_high idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_sat_low();
        ch_sel = 2'd1;
        cfg_write(2'd1, 4'd1);
        repeat (2) press(1'b0, 1'b1);
        exp_duty[1] = 0;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL sat_low idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_clamp();
        ch_sel = 2'd1;
        cfg_write(2'd1, 4'd15);
        exp_duty[1] = 10;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL clamp idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_inc_dec_same();
        ch_sel = 2'd3;
        press(1'b1, 1'b1);
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL inc_dec_same idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
    endtask

    // cfg_we is held across the whole press so the inc event must coincide with it and be dropped.
    task automatic test_cfg_vs_button();
        ch_sel = 2'd3;
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = 2'd0;
        cfg_duty = 4'd3;
        press(1'b1, 1'b0);
        cfg_we   = 1'b0;
        exp_duty[0] = 3;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL cfg_vs_button idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_ena_low();
        int k;
        wait_frame();
        repeat (3) @(negedge clk);
        ena = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_checks++;
            if (pwm_out !== 4'h0 || frame_start !== 1'b0)
                $display("FAIL ena_low cyc%0d pwm=%h fs=%b exp pwm=0 fs=0", c, pwm_out, frame_start);
            else n_pass++;
        end
        ena = 1'b1;
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) break;
        end
        n_checks++;
        if (k != 7) $display("FAIL ena_resume got_cycle=%0d exp_cycle=7", k); else n_pass++;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL ena_after idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        wait_frame();
        @(posedge clk);
        #2;
        n_checks++;
        if (pwm_out !== 4'hF) $display("FAIL pre_reset_pwm got=%h exp=f", pwm_out); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pwm_out !== 4'h0) $display("FAIL async_reset_pwm got=%h exp=0", pwm_out); else n_pass++;
        n_checks++;
        if (duty_mon !== 4'd5) $display("FAIL async_reset_mon got=%0d exp=5", duty_mon); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) exp_duty[i] = 5;
        push_expect();
        measure_frame();
        for (int i = 0; i <= NCH; i++) begin
            int got = (i < NCH) ? obs_hi[i] : int'(duty_mon);
            int e   = sb_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL after_reset idx%0d got=%0d exp=%0d", i, got, e); else n_pass++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        inc_btn  = 1'b0;
        dec_btn  = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_duty = '0;
        ch_sel   = '0;
        test_reset();
        test_defaults();
        test_inc_press();
        test_bouncy();
        test_sat_high();
        test_sat_low();
        test_clamp();
        test_inc_dec_same();
        test_cfg_vs_button();
        test_ena_low();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
